// File: rtl/alu_bist.sv
// Exhaustive built-in self-test for the alu block: sweeps every opcode/a/b/cin vector and checks y/cout.
// Optional flag checking of alu_negative/alu_zero is built only when ALU_BIST_FLAGS_EN is defined.

package alu_ops;
    localparam logic [3:0] LL_SHIFT_OP = 4'd0;
    localparam logic [3:0] LR_SHIFT_OP = 4'd1;
    localparam logic [3:0] AL_SHIFT_OP = 4'd2;
    localparam logic [3:0] AR_SHIFT_OP = 4'd3;
    localparam logic [3:0] NOT_OP      = 4'd4;
    localparam logic [3:0] AND_OP      = 4'd5;
    localparam logic [3:0] OR_OP       = 4'd6;
    localparam logic [3:0] XOR_OP      = 4'd7;
    localparam logic [3:0] SUB_OP      = 4'd8;
    localparam logic [3:0] ADD_OP      = 4'd9;
endpackage

module alu_bist #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_opcode,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    input  logic             alu_negative,
    input  logic             alu_zero
);

    localparam int VEC_W = 4 + 2*WIDTH + 1;
    localparam logic [WIDTH:0] W_LIM = (WIDTH+1)'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_FINISH,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Vector counter packs {op index, a, b, cin} so one increment walks the nested loops.
    logic [VEC_W-1:0] r_vec;
    logic             w_vec_last;

    logic [3:0]       r_alu_opcode;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_alu_cin;

    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_fail_opcode;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic             r_fail_cin;

    logic [WIDTH-1:0] w_y_exp;
    logic             w_cout_exp;
    logic             w_cmp_cout;
    logic             w_shift_big;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_mismatch;

    function automatic logic [3:0] op_of_idx(input logic [3:0] idx);
        logic [3:0] op;
        case (idx)
            4'd0:    op = alu_ops::LL_SHIFT_OP;
            4'd1:    op = alu_ops::LR_SHIFT_OP;
            4'd2:    op = alu_ops::AL_SHIFT_OP;
            4'd3:    op = alu_ops::AR_SHIFT_OP;
            4'd4:    op = alu_ops::NOT_OP;
            4'd5:    op = alu_ops::AND_OP;
            4'd6:    op = alu_ops::OR_OP;
            4'd7:    op = alu_ops::XOR_OP;
            4'd8:    op = alu_ops::SUB_OP;
            4'd9:    op = alu_ops::ADD_OP;
            default: op = alu_ops::LL_SHIFT_OP;
        endcase
        return op;
    endfunction

    assign w_vec_last = (r_vec[VEC_W-1 -: 4] == 4'd9) && (&r_vec[2*WIDTH:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                busy   = 1'b1;
                w_next = S_CHECK;
            end
            S_CHECK: begin
                busy   = 1'b1;
                w_next = w_vec_last ? S_FINISH : S_DRIVE;
            end
            S_FINISH: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next = S_DRIVE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Golden model evaluates the vector currently presented on the alu_* registers.
    always_comb begin
        w_y_exp     = '0;
        w_cout_exp  = 1'b0;
        w_cmp_cout  = 1'b0;
        w_shift_big = ({1'b0, r_alu_b} >= W_LIM);
        w_sum       = {1'b0, r_alu_a} + {1'b0, r_alu_b} + {{WIDTH{1'b0}}, r_alu_cin};
        w_diff      = {1'b0, r_alu_a} - {1'b0, r_alu_b} - {{WIDTH{1'b0}}, r_alu_cin};
        case (r_alu_opcode)
            alu_ops::LL_SHIFT_OP,
            alu_ops::AL_SHIFT_OP: w_y_exp = w_shift_big ? '0 : (r_alu_a << r_alu_b);
            alu_ops::LR_SHIFT_OP: w_y_exp = w_shift_big ? '0 : (r_alu_a >> r_alu_b);
            alu_ops::AR_SHIFT_OP: w_y_exp = w_shift_big ? {WIDTH{r_alu_a[WIDTH-1]}}
                                                        : WIDTH'($signed(r_alu_a) >>> r_alu_b);
            alu_ops::NOT_OP:      w_y_exp = ~r_alu_a;
            alu_ops::AND_OP:      w_y_exp = r_alu_a & r_alu_b;
            alu_ops::OR_OP:       w_y_exp = r_alu_a | r_alu_b;
            alu_ops::XOR_OP:      w_y_exp = r_alu_a ^ r_alu_b;
            alu_ops::SUB_OP: begin
                w_y_exp    = w_diff[WIDTH-1:0];
                w_cout_exp = w_diff[WIDTH];
                w_cmp_cout = 1'b1;
            end
            alu_ops::ADD_OP: begin
                w_y_exp    = w_sum[WIDTH-1:0];
                w_cout_exp = w_sum[WIDTH];
                w_cmp_cout = 1'b1;
            end
            default: w_y_exp = '0;
        endcase
    end

`ifdef ALU_BIST_FLAGS_EN
    logic w_flag_mis;
    assign w_flag_mis = (alu_negative != w_y_exp[WIDTH-1]) || (alu_zero != (w_y_exp == '0));
    assign w_mismatch = (alu_y != w_y_exp) || (w_cmp_cout && (alu_cout != w_cout_exp)) || w_flag_mis;
`else
    logic w_flags_unused;
    assign w_flags_unused = alu_negative ^ alu_zero;
    assign w_mismatch     = (alu_y != w_y_exp) || (w_cmp_cout && (alu_cout != w_cout_exp));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec         <= '0;
            r_alu_opcode  <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_cin     <= 1'b0;
            r_pass        <= 1'b0;
            r_err         <= '0;
            r_fail_opcode <= '0;
            r_fail_a      <= '0;
            r_fail_b      <= '0;
            r_fail_cin    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_vec         <= '0;
                        r_pass        <= 1'b0;
                        r_err         <= '0;
                        r_fail_opcode <= '0;
                        r_fail_a      <= '0;
                        r_fail_b      <= '0;
                        r_fail_cin    <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    r_alu_opcode <= op_of_idx(r_vec[VEC_W-1 -: 4]);
                    r_alu_a      <= r_vec[2*WIDTH -: WIDTH];
                    r_alu_b      <= r_vec[WIDTH -: WIDTH];
                    r_alu_cin    <= r_vec[0];
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err != '1) begin
                            r_err <= r_err + ERR_W'(1);
                        end
                        // err_count is cleared at start and never wraps, so zero marks the first miss.
                        if (r_err == '0) begin
                            r_fail_opcode <= r_alu_opcode;
                            r_fail_a      <= r_alu_a;
                            r_fail_b      <= r_alu_b;
                            r_fail_cin    <= r_alu_cin;
                        end
                    end
                    r_vec <= r_vec + VEC_W'(1);
                end
                S_FINISH: begin
                    r_pass <= (r_err == '0);
                end
                default: ;
            endcase
        end
    end

    assign pass        = r_pass;
    assign err_count   = r_err;
    assign fail_opcode = r_fail_opcode;
    assign fail_a      = r_fail_a;
    assign fail_b      = r_fail_b;
    assign fail_cin    = r_fail_cin;
    assign alu_opcode  = r_alu_opcode;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_cin     = r_alu_cin;

endmodule
